// File: rtl/instruction_fetch.sv
// Fetch stage for a single-issue RV32I core: owns the PC, issues one word read
// at a time, and holds one {instruction, pc} pair for decode. An execute-stage
// redirect retargets the PC and squashes any in-flight wrong-path fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    // REQ: may issue; WAIT: response will be used; WAIT_DROP: response is wrong-path
    typedef enum logic [1:0] {
        S_REQ       = 2'd0,
        S_WAIT      = 2'd1,
        S_WAIT_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic slot_free;
    logic accept;

    // The output slot may be (re)filled when empty or when decode drains it this cycle.
    // A redirect masks the request so the old PC never goes out on the redirect cycle.
    always_comb begin
        slot_free = !if_valid_q || id_ready;
        imem_req  = reset_n && (state_q == S_REQ) && slot_free && !redirect_valid;
        accept    = imem_req && imem_gnt;
    end

    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

    // Next-state: redirect has priority over everything, then consume/fill per state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'h3;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            unique case (state_q)
                S_REQ:       state_d = S_REQ;
                S_WAIT:      state_d = imem_rvalid ? S_REQ : S_WAIT_DROP;
                S_WAIT_DROP: state_d = imem_rvalid ? S_REQ : S_WAIT_DROP;
                default:     state_d = S_REQ;
            endcase
        end else begin
            if (if_valid_q && id_ready) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
            unique case (state_q)
                S_REQ: begin
                    // Stale responses arriving here are ignored
                    if (accept) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // pc_q already points past the outstanding word
                    if (imem_rvalid) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q - 32'd4;
                        if_valid_d = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                S_WAIT_DROP: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and output-slot registers; async reset loses any outstanding response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. Inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    int compared   = 0;
    int mismatched = 0;

    instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (inputs are applied there)
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc",    if_pc, RST_PC);
        chk("rst_addr",  imem_addr, RST_PC);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);

        // 1: first fetch from RESET_PC
        nxt(); reset_n = 1'b1; imem_gnt = 1'b1; #1;
        chk("t1_req",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h100);
        nxt(); imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        nxt(); imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
        chk("t1_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_instr", if_instr, 32'h0050_0093);
        chk("t1_pc",    if_pc, 32'h100);
        chk("t1_next",  imem_addr, 32'h104);

        // 2: decode stall holds the slot and blocks requests
        for (int i = 0; i < 5; i++) begin
            nxt(); #1;
            chk("t2_req_stall", {31'd0, imem_req}, 32'd0);
            chk("t2_instr_hold", if_instr, 32'h0050_0093);
            chk("t2_pc_hold", if_pc, 32'h100);
        end
        nxt(); id_ready = 1'b1; #1;
        chk("t2_req_ready", {31'd0, imem_req}, 32'd1);
        chk("t2_addr", imem_addr, 32'h104);
        imem_gnt = 1'b1;

        // 3: redirect in WAIT, late response dropped
        nxt(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        chk("t3_consumed", {31'd0, if_valid}, 32'd0);
        chk("t3_req_masked", {31'd0, imem_req}, 32'd0);
        nxt(); redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        chk("t3_drop_addr", imem_addr, 32'h200);
        chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
        nxt(); imem_rvalid = 1'b0; #1;
        chk("t3_valid", {31'd0, if_valid}, 32'd0);
        chk("t3_instr", if_instr, NOP);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h200);

        // 4: redirect coincident with rvalid in WAIT, misaligned target
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
        nxt(); imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        // redirect in REQ masks the request on that cycle
        redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
        chk("t4_req_masked", {31'd0, imem_req}, 32'd0);
        nxt(); redirect_valid = 1'b0; #1;
        chk("t4_req_after", {31'd0, imem_req}, 32'd1);
        chk("t4_addr_after", imem_addr, 32'h300);

        // 5: redirect while decode stalls, then PC wrap
        imem_gnt = 1'b1; id_ready = 1'b0;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        nxt(); imem_rvalid = 1'b0; #1;
        chk("t5_valid", {31'd0, if_valid}, 32'd1);
        chk("t5_pc", if_pc, 32'h300);
        chk("t5_instr", if_instr, 32'h00A0_0113);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        nxt(); redirect_valid = 1'b0; #1;
        chk("t5_squash_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_squash_instr", if_instr, NOP);
        chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("t5_top_req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; #1;
        chk("t5_wrap_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        nxt(); imem_rvalid = 1'b0; id_ready = 1'b1; #1;
        chk("t5_wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_wrap_instr", if_instr, 32'h1234_5678);
        chk("t5_wrap_req", {31'd0, imem_req}, 32'd1);
        nxt(); #1;
        chk("t5_drain_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_drain_instr", if_instr, NOP);

        // 6: reset during WAIT, stale response ignored
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; reset_n = 1'b0; #1;
        chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_rst_instr", if_instr, NOP);
        chk("t6_rst_pc", if_pc, RST_PC);
        chk("t6_rst_addr", imem_addr, RST_PC);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        nxt(); reset_n = 1'b1; id_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; #1;
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        nxt(); imem_rvalid = 1'b0; #1;
        chk("t6_stale_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_stale_addr", imem_addr, RST_PC);
        imem_gnt = 1'b1;
        nxt(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
        nxt(); imem_rvalid = 1'b0; #1;
        chk("t6_fetch_valid", {31'd0, if_valid}, 32'd1);
        chk("t6_fetch_pc", if_pc, RST_PC);
        chk("t6_fetch_instr", if_instr, 32'h0010_0073);
        chk("t6_fetch_next", imem_addr, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
